// File: rtl/eda_scan_ctrl_pkg.sv
// Shared types and constants for the window-scan controller.
// Neighbour bit positions match the nbr_valid ordering.
`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH 4
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 2
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 2
`endif

package eda_scan_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_CMP,
      S_MARK,
      S_ADVANCE,
      S_DONE
   } scan_state_e;

   localparam int NB_COUNT = 8;
   localparam int NB_UL    = 7;
   localparam int NB_UP    = 6;
   localparam int NB_UR    = 5;
   localparam int NB_LF    = 4;
   localparam int NB_RT    = 3;
   localparam int NB_DL    = 2;
   localparam int NB_DN    = 1;
   localparam int NB_DR    = 0;

   function automatic int nbr_di(input int k);
      case (k)
         NB_UL, NB_UP, NB_UR: return -1;
         NB_DL, NB_DN, NB_DR: return 1;
         default:             return 0;
      endcase
   endfunction

   function automatic int nbr_dj(input int k);
      case (k)
         NB_UL, NB_LF, NB_DL: return -1;
         NB_UR, NB_RT, NB_DR: return 1;
         default:             return 0;
      endcase
   endfunction

endpackage

// File: rtl/eda_scan_ctrl_nbr_addr_gen.sv
// Combinational 3x3 window address generator.
// Out-of-image neighbours fall back to the centre address.
module eda_nbr_addr_gen
   import eda_scan_ctrl_pkg::*;
#(
   parameter int M          = `CFG_M,
   parameter int N          = `CFG_N,
   parameter int ADDR_WIDTH = `CFG_ADDR_WIDTH,
   parameter int I_WIDTH    = `CFG_I_WIDTH,
   parameter int J_WIDTH    = `CFG_J_WIDTH
) (
   input  logic [I_WIDTH-1:0]                    i_i,
   input  logic [J_WIDTH-1:0]                    j_i,
   output logic [NB_COUNT-1:0][ADDR_WIDTH-1:0]   addr_o,
   output logic [NB_COUNT-1:0]                   valid_o
);

   logic [ADDR_WIDTH-1:0] center;
   int                    ni_v;
   int                    nj_v;

   assign center = {i_i, j_i};

   always_comb begin
      addr_o  = '0;
      valid_o = '0;
      ni_v    = 0;
      nj_v    = 0;
      for (int k = 0; k < NB_COUNT; k++) begin
         ni_v = int'(i_i) + nbr_di(k);
         nj_v = int'(j_i) + nbr_dj(k);
         if (ni_v >= 0 && ni_v < M && nj_v >= 0 && nj_v < N) begin
            valid_o[k] = 1'b1;
            addr_o[k]  = {ni_v[I_WIDTH-1:0], nj_v[J_WIDTH-1:0]};
         end else begin
            addr_o[k]  = center;
         end
      end
   end

endmodule

// File: rtl/eda_scan_ctrl.sv
// Raster-scan controller issuing 3x3 window requests per pixel,
// reporting regional maxima and driving strobe-RAM updates.
`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH 4
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 2
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 2
`endif

module eda_scan_ctrl
   import eda_scan_ctrl_pkg::*;
#(
   parameter int M          = `CFG_M,
   parameter int N          = `CFG_N,
   parameter int ADDR_WIDTH = `CFG_ADDR_WIDTH,
   parameter int I_WIDTH    = `CFG_I_WIDTH,
   parameter int J_WIDTH    = `CFG_J_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  abort,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic [ADDR_WIDTH-1:0] center_addr,
   output logic [ADDR_WIDTH-1:0] upleft_addr,
   output logic [ADDR_WIDTH-1:0] up_addr,
   output logic [ADDR_WIDTH-1:0] upright_addr,
   output logic [ADDR_WIDTH-1:0] left_addr,
   output logic [ADDR_WIDTH-1:0] right_addr,
   output logic [ADDR_WIDTH-1:0] downleft_addr,
   output logic [ADDR_WIDTH-1:0] down_addr,
   output logic [ADDR_WIDTH-1:0] downright_addr,
   output logic [7:0]            nbr_valid,
   input  logic                  cmp_valid,
   input  logic                  cmp_is_max,
   output logic                  update_strb,
   output logic                  new_pixel,
   output logic [ADDR_WIDTH-1:0] pre_center_addr,
   output logic [M-1:0]          sel_row,
   output logic [M*N-1:0]        sel_col,
   output logic                  max_valid,
   output logic [ADDR_WIDTH-1:0] max_addr,
   output logic                  busy,
   output logic                  done
);

   scan_state_e                state_q, state_d;
   logic [I_WIDTH-1:0]         i_q, i_d;
   logic [J_WIDTH-1:0]         j_q, j_d;
   logic [I_WIDTH-1:0]         nxt_i;
   logic [J_WIDTH-1:0]         nxt_j;
   logic                       col_wrap;
   logic                       last_pix;
   logic [ADDR_WIDTH-1:0]      cur_addr;

   logic [NB_COUNT-1:0][ADDR_WIDTH-1:0] nb_addr;
   logic [NB_COUNT-1:0]                 nb_valid;

   eda_nbr_addr_gen #(
      .M          (M),
      .N          (N),
      .ADDR_WIDTH (ADDR_WIDTH),
      .I_WIDTH    (I_WIDTH),
      .J_WIDTH    (J_WIDTH)
   ) u_nbr (
      .i_i     (i_q),
      .j_i     (j_q),
      .addr_o  (nb_addr),
      .valid_o (nb_valid)
   );

   assign busy     = (state_q != S_IDLE);
   assign cur_addr = {i_q, j_q};
   assign col_wrap = (j_q == J_WIDTH'(N-1));
   assign last_pix = col_wrap && (i_q == I_WIDTH'(M-1));
   assign nxt_j    = col_wrap ? '0 : j_q + J_WIDTH'(1);
   assign nxt_i    = col_wrap ? i_q + I_WIDTH'(1) : i_q;

   // Addresses are only meaningful while a scan is running.
   assign center_addr    = busy ? cur_addr        : '0;
   assign upleft_addr    = busy ? nb_addr[NB_UL]  : '0;
   assign up_addr        = busy ? nb_addr[NB_UP]  : '0;
   assign upright_addr   = busy ? nb_addr[NB_UR]  : '0;
   assign left_addr      = busy ? nb_addr[NB_LF]  : '0;
   assign right_addr     = busy ? nb_addr[NB_RT]  : '0;
   assign downleft_addr  = busy ? nb_addr[NB_DL]  : '0;
   assign down_addr      = busy ? nb_addr[NB_DN]  : '0;
   assign downright_addr = busy ? nb_addr[NB_DR]  : '0;
   assign nbr_valid      = busy ? nb_valid        : '0;

   always_comb begin
      state_d         = state_q;
      i_d             = i_q;
      j_d             = j_q;
      req_valid       = 1'b0;
      new_pixel       = 1'b0;
      update_strb     = 1'b0;
      max_valid       = 1'b0;
      max_addr        = '0;
      pre_center_addr = '0;
      sel_row         = '0;
      sel_col         = '0;
      done            = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ISSUE;
               i_d     = '0;
               j_d     = '0;
            end
         end
         S_ISSUE: begin
            req_valid = 1'b1;
            if (req_ready) state_d = S_WAIT_CMP;
         end
         S_WAIT_CMP: begin
            if (cmp_valid) begin
               state_d = S_MARK;
               if (cmp_is_max) begin
                  max_valid = 1'b1;
                  max_addr  = cur_addr;
               end
            end
         end
         S_MARK: begin
            new_pixel       = 1'b1;
            pre_center_addr = cur_addr;
            state_d         = S_ADVANCE;
         end
         S_ADVANCE: begin
            if (last_pix) begin
               state_d = S_DONE;
            end else begin
               new_pixel      = 1'b1;
               update_strb    = 1'b1;
               sel_row[nxt_i] = 1'b1;
               for (int r = 0; r < M; r++) begin
                  sel_col[r*N + int'(nxt_j)] = 1'b1;
               end
               i_d     = nxt_i;
               j_d     = nxt_j;
               state_d = S_ISSUE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Abort wins over everything and leaves no side effects behind.
      if (abort && busy) begin
         state_d     = S_IDLE;
         i_d         = '0;
         j_d         = '0;
         new_pixel   = 1'b0;
         update_strb = 1'b0;
         max_valid   = 1'b0;
         max_addr    = '0;
         sel_row     = '0;
         sel_col     = '0;
         done        = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         j_q     <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
      end
   end

endmodule

// File: tb/tb_eda_scan_ctrl.sv
// Self-checking bench for eda_scan_ctrl on a 4x4 image.
// Expected values come from pixel arithmetic on linear index p.
module tb_eda_scan_ctrl;

   localparam int M  = 4;
   localparam int N  = 4;
   localparam int AW = 4;
   localparam int IW = 2;
   localparam int JW = 2;

   logic          clk;
   logic          reset_n;
   logic          start;
   logic          abort;
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] center_addr;
   logic [AW-1:0] upleft_addr, up_addr, upright_addr, left_addr;
   logic [AW-1:0] right_addr, downleft_addr, down_addr, downright_addr;
   logic [7:0]    nbr_valid;
   logic          cmp_valid;
   logic          cmp_is_max;
   logic          update_strb;
   logic          new_pixel;
   logic [AW-1:0] pre_center_addr;
   logic [M-1:0]  sel_row;
   logic [M*N-1:0] sel_col;
   logic          max_valid;
   logic [AW-1:0] max_addr;
   logic          busy;
   logic          done;

   logic [AW-1:0] nb [8];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int mark_cnt = 0;
   int adv_cnt = 0;
   int max_cnt = 0;
   int done_cnt = 0;
   int c0;

   eda_scan_ctrl #(
      .M(M), .N(N), .ADDR_WIDTH(AW), .I_WIDTH(IW), .J_WIDTH(JW)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .abort           (abort),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .center_addr     (center_addr),
      .upleft_addr     (upleft_addr),
      .up_addr         (up_addr),
      .upright_addr    (upright_addr),
      .left_addr       (left_addr),
      .right_addr      (right_addr),
      .downleft_addr   (downleft_addr),
      .down_addr       (down_addr),
      .downright_addr  (downright_addr),
      .nbr_valid       (nbr_valid),
      .cmp_valid       (cmp_valid),
      .cmp_is_max      (cmp_is_max),
      .update_strb     (update_strb),
      .new_pixel       (new_pixel),
      .pre_center_addr (pre_center_addr),
      .sel_row         (sel_row),
      .sel_col         (sel_col),
      .max_valid       (max_valid),
      .max_addr        (max_addr),
      .busy            (busy),
      .done            (done)
   );

   assign nb[7] = upleft_addr;
   assign nb[6] = up_addr;
   assign nb[5] = upright_addr;
   assign nb[4] = left_addr;
   assign nb[3] = right_addr;
   assign nb[2] = downleft_addr;
   assign nb[1] = down_addr;
   assign nb[0] = downright_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset_n) begin
         if (new_pixel && !update_strb) mark_cnt <= mark_cnt + 1;
         if (update_strb) adv_cnt <= adv_cnt + 1;
         if (max_valid) max_cnt <= max_cnt + 1;
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Row offset: bits 7..5 look up, bits 2..0 look down.
   function automatic int ddi(input int k);
      if (k >= 5) return -1;
      if (k <= 2) return 1;
      return 0;
   endfunction

   // Column offset: UL/L/DL look left, UR/R/DR look right.
   function automatic int ddj(input int k);
      if (k == 7 || k == 4 || k == 2) return -1;
      if (k == 5 || k == 3 || k == 0) return 1;
      return 0;
   endfunction

   task automatic nbr_chk(input int p);
      int i;
      int j;
      logic [7:0] ev;
      i = p / N;
      j = p % N;
      ev = '0;
      chk("center_addr", center_addr, p);
      for (int k = 0; k < 8; k++) begin
         int ni;
         int nj;
         int ea;
         ni = i + ddi(k);
         nj = j + ddj(k);
         if (ni >= 0 && ni < M && nj >= 0 && nj < N) begin
            ev[k] = 1'b1;
            ea = ni * N + nj;
         end else begin
            ea = p;
         end
         chk($sformatf("nbr%0d_addr_p%0d", k, p), nb[k], ea);
      end
      chk($sformatf("nbr_valid_p%0d", p), nbr_valid, ev);
   endtask

   // cut: 0 = complete pixel, 1 = abort in WAIT_CMP, 2 = reset in ADVANCE
   task automatic do_pixel(input int p, input int rdly, input int cdly,
                           input bit mx, input int cut);
      int q;
      logic [M*N-1:0] ecol;
      q = p + 1;
      req_ready = 1'b0;
      for (int d = 0; d < rdly; d++) begin
         start      = 1'($urandom_range(0, 1));
         cmp_valid  = 1'($urandom_range(0, 1));
         cmp_is_max = 1'b1;
         #1;
         chk("issue_hold_req", req_valid, 1);
         chk("issue_ignores_cmp", max_valid, 0);
         nbr_chk(p);
         tick();
      end
      start      = 1'b0;
      cmp_valid  = 1'b0;
      cmp_is_max = 1'b0;
      req_ready  = 1'b1;
      #1;
      chk("issue_req", req_valid, 1);
      chk("issue_busy", busy, 1);
      nbr_chk(p);
      if (p == 0) chk("corner00_mask", nbr_valid, 8'b0000_1011);
      if (p == M*N-1) chk("corner33_mask", nbr_valid, 8'b1101_0000);
      tick();
      req_ready = 1'b0;
      for (int c = 0; c < cdly; c++) begin
         cmp_is_max = 1'($urandom_range(0, 1));
         #1;
         chk("wait_no_req", req_valid, 0);
         chk("wait_no_max", max_valid, 0);
         tick();
      end
      cmp_is_max = 1'b0;
      if (cut == 1) begin
         abort = 1'b1;
         #1;
         chk("abort_wait_req", req_valid, 0);
         chk("abort_wait_busy", busy, 1);
         tick();
         abort = 1'b0;
         #1;
         chk("abort_idle_busy", busy, 0);
         chk("abort_idle_done", done, 0);
         chk("abort_idle_req", req_valid, 0);
         chk("abort_idle_newpix", new_pixel, 0);
         return;
      end
      cmp_valid  = 1'b1;
      cmp_is_max = mx;
      #1;
      chk("wait_no_req_cmp", req_valid, 0);
      chk("max_valid", max_valid, mx);
      chk("max_addr", max_addr, mx ? p : 0);
      tick();
      cmp_valid  = 1'b0;
      cmp_is_max = 1'b0;
      #1;
      chk("mark_newpix", new_pixel, 1);
      chk("mark_upd", update_strb, 0);
      chk("mark_pre_center", pre_center_addr, p);
      chk("mark_no_req", req_valid, 0);
      tick();
      #1;
      if (cut == 2) begin
         chk("adv_before_rst", new_pixel, 1);
         reset_n = 1'b0;
         #1;
         chk("rst_newpix", new_pixel, 0);
         chk("rst_upd", update_strb, 0);
         chk("rst_busy", busy, 0);
         chk("rst_req", req_valid, 0);
         chk("rst_center", center_addr, 0);
         chk("rst_right", right_addr, 0);
         chk("rst_mask", nbr_valid, 0);
         chk("rst_sel_row", sel_row, 0);
         chk("rst_sel_col", sel_col, 0);
         chk("rst_done", done, 0);
         return;
      end
      ecol = '0;
      if (q < M*N) begin
         for (int r = 0; r < M; r++) ecol[r*N + (q % N)] = 1'b1;
         chk("adv_newpix", new_pixel, 1);
         chk("adv_upd", update_strb, 1);
         chk("adv_sel_row", sel_row, 1 << (q / N));
         chk("adv_sel_col", sel_col, ecol);
         if (p == 7) begin
            chk("wrap_sel_row", sel_row, 4'b0100);
            chk("wrap_sel_col", sel_col, 16'h1111);
         end
      end else begin
         chk("last_adv_newpix", new_pixel, 0);
         chk("last_adv_upd", update_strb, 0);
         chk("last_adv_sel_row", sel_row, 0);
         chk("last_adv_sel_col", sel_col, 0);
      end
      tick();
   endtask

   task automatic start_scan();
      start = 1'b1;
      tick();
      start = 1'b0;
      c0 = cyc;
   endtask

   task automatic run_scan(input bit rnd, input int max_p);
      int m0, a0, x0, d0, exp_max;
      bit mx;
      int rd, cd;
      m0 = mark_cnt;
      a0 = adv_cnt;
      x0 = max_cnt;
      d0 = done_cnt;
      exp_max = 0;
      start_scan();
      for (int p = 0; p < M*N; p++) begin
         if (rnd) begin
            rd = (p == 0) ? 5 : $urandom_range(0, 3);
            cd = $urandom_range(0, 2);
            mx = ($urandom_range(0, 3) == 0);
         end else begin
            rd = 0;
            cd = 0;
            mx = (p == max_p);
         end
         if (mx) exp_max++;
         do_pixel(p, rd, cd, mx, 0);
      end
      #1;
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 1);
      if (!rnd) chk("done_latency", cyc - c0, 64);
      tick();
      #1;
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("mark_cycles", mark_cnt - m0, M*N);
      chk("adv_cycles", adv_cnt - a0, M*N - 1);
      chk("max_pulses", max_cnt - x0, exp_max);
      chk("done_pulses", done_cnt - d0, 1);
   endtask

   initial begin
      int d0;
      reset_n    = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      req_ready  = 1'b0;
      cmp_valid  = 1'b0;
      cmp_is_max = 1'b0;
      tick();
      tick();
      chk("reset_busy", busy, 0);
      chk("reset_req", req_valid, 0);
      chk("reset_center", center_addr, 0);
      chk("reset_downright", downright_addr, 0);
      chk("reset_mask", nbr_valid, 0);
      chk("reset_sel_row", sel_row, 0);
      chk("reset_sel_col", sel_col, 0);
      chk("reset_done", done, 0);
      chk("reset_newpix", new_pixel, 0);
      reset_n = 1'b1;
      tick();
      tick();
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_req", req_valid, 0);

      run_scan(1'b0, 9);
      run_scan(1'b1, 0);

      d0 = done_cnt;
      start_scan();
      do_pixel(0, 0, 0, 1'b0, 0);
      do_pixel(1, 1, 1, 1'b0, 1);
      tick();
      tick();
      #1;
      chk("abort_stays_idle", busy, 0);
      chk("abort_no_done", done_cnt - d0, 0);

      start_scan();
      do_pixel(0, 0, 0, 1'b0, 0);
      do_pixel(1, 0, 0, 1'b0, 0);
      do_pixel(2, 0, 0, 1'b0, 2);
      tick();
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         #1;
         chk("post_rst_busy", busy, 0);
         chk("post_rst_req", req_valid, 0);
         chk("post_rst_newpix", new_pixel, 0);
      end
      run_scan(1'b0, 15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/eda_scan_ctrl.md
EDA_SCAN_CTRL -- requirements
Module: eda_scan_ctrl

Interface
REQ-001 Parameters (name, default, meaning): M, `CFG_M, image rows; N, `CFG_N, image columns; ADDR_WIDTH, `CFG_ADDR_WIDTH, pixel address width; I_WIDTH, `CFG_I_WIDTH, row index width; J_WIDTH, `CFG_J_WIDTH, column index width.
REQ-002 Pixel address format SHALL be {i, j}: i in bits [ADDR_WIDTH-1:J_WIDTH], j in bits [J_WIDTH-1:0].
REQ-003 Ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1, single clock; rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin scan; sampled only in IDLE.
- abort, in, 1, synchronous abort of a running scan.
- req_valid / req_ready, out / in, 1 / 1, window-request handshake to the compare unit.
- center_addr, out, ADDR_WIDTH, address of the current pixel.
- upleft_addr … downright_addr (8 ports), out, ADDR_WIDTH each, neighbour addresses.
- nbr_valid, out, 8, in-bounds mask; bit7 = upleft … bit0 = downright, same order as the neighbour ports.
- cmp_valid, in, 1, compare result strobe.
- cmp_is_max, in, 1, current pixel is a regional maximum.
- update_strb, out, 1, strobe-RAM update select.
- new_pixel, out, 1, strobe-RAM write enable.
- pre_center_addr, out, ADDR_WIDTH, strobe-RAM mark address.
- sel_row, out, M, one-hot next row.
- sel_col, out, M×N, one-hot next column.
- max_valid, out, 1, one-cycle maximum report.
- max_addr, out, ADDR_WIDTH, address of the reported maximum.
- busy, out, 1, scan in progress.
- done, out, 1, one-cycle end-of-scan pulse.

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, WAIT_CMP, MARK, ADVANCE, DONE.
REQ-005 IDLE→ISSUE on start=1; the current pixel SHALL be set to (0,0).
REQ-006 ISSUE SHALL hold req_valid=1 with stable addresses and mask until req_valid&req_ready, then go to WAIT_CMP.
REQ-007 WAIT_CMP→MARK on cmp_valid=1; if cmp_is_max=1 in that cycle, max_valid=1 and max_addr=center_addr SHALL be driven in that same cycle.
REQ-008 cmp_valid outside WAIT_CMP SHALL be ignored.
REQ-009 MARK SHALL last exactly 1 cycle with new_pixel=1, update_strb=0, pre_center_addr=center_addr.
REQ-010 ADVANCE, when the current pixel ≠ (M-1,N-1):
- 1 cycle with new_pixel=1, update_strb=1;
- sel_row one-hot at the next row; every row of sel_col one-hot at the next column;
- then advance to the next pixel and go to ISSUE.
REQ-011 ADVANCE at (M-1,N-1) SHALL go to DONE with new_pixel=0.
REQ-012 DONE SHALL assert done=1 for 1 cycle, then go to IDLE.
REQ-013 Scan order SHALL be row-major: j increments; at j=N-1, j wraps to 0 and i increments.
REQ-014 Neighbour handling: a neighbour with row or column outside [0,M-1]×[0,N-1] SHALL have its nbr_valid bit = 0 and its address driven equal to center_addr.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 start while busy SHALL be ignored.
REQ-017 abort=1 in any non-IDLE state SHALL go to IDLE next cycle, with req_valid, new_pixel, update_strb=0 and no done pulse; abort has priority over all other transitions.
REQ-018 Minimum per-pixel latency SHALL be 4 cycles (req_ready and cmp_valid both immediate).
REQ-019 Outside the states that drive them, req_valid, new_pixel, update_strb, max_valid and done SHALL be 0, and sel_row and sel_col SHALL be all-zero.
REQ-020 Combinational outputs SHALL be decoded from registered state and index only; there SHALL be no combinational path from any input to req_valid.

Reset
REQ-021 reset_n=0 SHALL asynchronously force state=IDLE and index=(0,0).
REQ-022 During reset, all 1-bit outputs SHALL be 0; all addresses SHALL be 0 with nbr_valid=0; sel_row and sel_col SHALL be all-zero.
REQ-023 Reset asserted mid-scan SHALL discard progress; after release, no output is asserted until a new start.

Structure
REQ-024 The state enum and neighbour-bit index constants SHALL live in the shared package alongside the existing CFG_* defines.
REQ-025 One sub-module, eda_nbr_addr_gen, SHALL be purely combinational and compute the 8 neighbour addresses and nbr_valid from (i,j).

Verification (M=4, N=4)
REQ-026 Full scan: start with req_ready=1 and cmp_valid=1 one cycle after each handshake → 16 MARK cycles, 15 ADVANCE cycles, done exactly 64 cycles after start.
REQ-027 Corner boundary: at pixel (0,0) → nbr_valid=8'b0000_1011; at (3,3) → nbr_valid=8'b1101_0000; every invalid address equals center_addr.
REQ-028 Backpressure: req_ready=0 for 5 cycles in ISSUE → req_valid and all addresses stay stable; WAIT_CMP entered only on the handshake cycle.
REQ-029 Row wrap: ADVANCE from (1,3) → sel_row=4'b0100, each sel_col row=4'b0001, next center_addr={2,0}.
REQ-030 cmp_is_max=1 at (2,1) → a single max_valid pulse with max_addr={2,1}.
REQ-031 Abort and reset: abort in WAIT_CMP → IDLE next cycle with no done pulse; reset_n low in ADVANCE → all outputs 0 immediately; a fresh start rescans from (0,0).
